imem_loader: RTL and testbench
==============================

# imem_loader

Program loader and write-port sequencer for the instruction memory. It takes a byte stream over a valid/ready handshake, packs it into little-endian 32-bit words, and writes them sequentially from word 0. It then pads every remaining word with the halt instruction and holds the CPU while loading. It sits between the host/UART byte source and the IMEM write port, and gives the core a deterministic program image without `$readmemh`.

## Interface
- `DEPTH`, default 128: IMEM depth in words; legal program range is words 0..DEPTH-1.
- `AW`, default 7: word-address width, equal to $clog2(DEPTH).
- `HALT_INSN`, default 32'h00000063: pad word (`beq x0, x0, 0`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a load. Honoured only in IDLE or DONE.
- `byte_valid`  in  1  source has a byte.
- `byte_data`  in  8  stream byte.
- `byte_last`  in  1  qualifies the final byte of the program; sampled with `byte_valid`.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `we`  out  1  IMEM write enable.
- `waddr`  out  AW  IMEM word address.
- `wdata`  out  32  IMEM write data.
- `cpu_hold`  out  1  stall or reset request to the core.
- `busy`  out  1  a load is in progress.
- `done`  out  1  level; the last load completed.
- `err_overflow`  out  1  level; the last load exceeded DEPTH words.
- `word_count`  out  AW+1  program words written, excluding pad words.

## Operation
- States: IDLE, RECV, WRITE, PAD, DRAIN, DONE.
- IDLE → RECV on `start`. In the same edge, clear the word pointer `ptr`, `byte_idx`, the assembly register, `word_count`, `done` and `err_overflow`.
- DONE → RECV on `start`, with the same clears.
- RECV:
  - `byte_ready` = 1.
  - On `byte_valid && byte_ready`, write the byte into lane `byte_idx` (byte 0 → bits 7:0).
  - If `byte_idx == 3` or `byte_last`, go to WRITE. Otherwise increment `byte_idx`.
  - Record `byte_last` in a `last_seen` flag.
- WRITE, one cycle:
  - `we` = 1, `waddr` = `ptr`, `wdata` = assembly register. Lanes above the final byte of a partial word are zero.
  - Increment `word_count`; clear `byte_idx` and the assembly register.
  - If `last_seen`: go to PAD if `ptr < DEPTH-1`, otherwise to DONE.
  - If not `last_seen`: go to DRAIN with `err_overflow` set if `ptr == DEPTH-1`. Otherwise increment `ptr` and go to RECV.
- PAD:
  - First increment `ptr`.
  - Then each cycle: `we` = 1, `wdata` = `HALT_INSN`, `waddr` = `ptr`.
  - After writing `DEPTH-1`, go to DONE.
- DRAIN:
  - `byte_ready` = 1; accepted bytes are discarded and nothing is written.
  - On an accepted `byte_last`, go to DONE.
- DONE: `done` = 1. Stays until the next `start`.
- `start` in RECV, WRITE, PAD or DRAIN is ignored.
- `cpu_hold` = `busy` = state ∈ {RECV, WRITE, PAD, DRAIN}.
- `word_count` saturates at DEPTH.
- Arithmetic: `ptr` is AW bits and never wraps (compares against DEPTH-1 before incrementing). `word_count` is AW+1 bits.

## Timing
- Reset values:
  - State IDLE.
  - `byte_ready`, `we`, `cpu_hold`, `busy`, `done`, `err_overflow` = 0.
  - `waddr` = 0, `wdata` = 0, `word_count` = 0.
- Every output is a function of registered state only. There is no combinational input→output path.
- `byte_ready` is 0 during WRITE, so the source sees backpressure one cycle per word. Throughput is 4 bytes per 5 cycles with continuous valid.
- IMEM write latency: the word is presented in the cycle after its 4th (or last) byte is accepted.
- Pad duration is exactly DEPTH-1-`ptr_final` cycles. DONE is entered on the edge after the final pad write.
- A `byte_valid` held high while `byte_ready` = 0 is not consumed; the source must hold `byte_data` and `byte_last`.
- `rst_n` asserted mid-load returns to IDLE immediately. The partially written IMEM is not restored, and `cpu_hold` drops.

## Structure
- Shared package `imem_pkg`: `IMEM_DEPTH` = 128, `HALT_INSN` = 32'h00000063, the `loader_state_t` enum, and the `IMEM_AW` localparam. The instruction memory uses the same constants for its out-of-range halt.
- Single module; no sub-module. The byte packer is a 2-bit index plus a 32-bit register and stays inline.

## Test plan
- Load 8 bytes 13 05 A0 00 93 05 10 00 (last on the 8th):
  - Writes word0 = 0x00A00513 and word1 = 0x00100593.
  - Then writes 126 words of 0x00000063 at addresses 2..127.
  - `word_count` = 2, `done` = 1, `err_overflow` = 0.
- Load 5 bytes AA BB CC DD EE (last on EE):
  - word0 = 0xDDCCBBAA, word1 = 0x000000EE.
  - Pad from address 2.
- Load exactly 512 bytes:
  - 128 writes with no PAD cycles.
  - DONE the cycle after the write to address 127.
  - `err_overflow` = 0.
- Load 520 bytes:
  - Writes stop at address 127.
  - The remaining 8 bytes are accepted and dropped.
  - `err_overflow` = 1, `word_count` = 128.
- Source stalls `byte_valid` randomly, and `start` pulses mid-load:
  - Image is identical to the unstalled run.
  - `start` is ignored while busy.
  - `byte_ready` is low on every WRITE cycle.
- Assert `rst_n` low during PAD:
  - All outputs return to reset values asynchronously.
  - A new `start` reloads correctly.

Source files
------------

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : IMEM geometry, pad instruction and loader state encoding.
// Revision    : 1.0
// ============================================================================
package imem_pkg;

    localparam int          IMEM_DEPTH = 128;
    localparam int          IMEM_AW    = $clog2(IMEM_DEPTH);
    localparam logic [31:0] HALT_INSN  = 32'h0000_0063;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_PAD   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } loader_state_t;

    // Little-endian lane insert: lane 0 occupies bits 7:0.
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
        logic [31:0] w_res;
        w_res = word;
        case (lane)
            2'd0:    w_res[7:0]   = b;
            2'd1:    w_res[15:8]  = b;
            2'd2:    w_res[23:16] = b;
            default: w_res[31:24] = b;
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte stream valid/ready channel from host source to loader.
// Revision    : 1.0
// ============================================================================
interface imem_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       byte_ready;

    modport master (output byte_valid, byte_data, byte_last, input byte_ready);
    modport slave  (input byte_valid, byte_data, byte_last, output byte_ready);
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Packs a byte stream into LE words, writes IMEM from word 0,
//               pads the remainder with HALT_INSN and holds the CPU meanwhile.
// Revision    : 1.0
// ============================================================================
module imem_loader #(
    parameter int          DEPTH     = imem_pkg::IMEM_DEPTH,
    parameter int          AW        = imem_pkg::IMEM_AW,
    parameter logic [31:0] HALT_INSN = imem_pkg::HALT_INSN
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          start,
    imem_loader_if.slave       src,
    output logic               we,
    output logic [AW-1:0]      waddr,
    output logic [31:0]        wdata,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               err_overflow,
    output logic [AW:0]        word_count
);
    import imem_pkg::*;

    localparam logic [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   c_CNT_MAX   = (AW+1)'(DEPTH);

    loader_state_t  r_state;
    logic [AW-1:0]  r_ptr;
    logic [1:0]     r_byte_idx;
    logic [31:0]    r_asm;
    logic           r_last_seen;
    logic           r_byte_ready;
    logic           r_we;
    logic [AW-1:0]  r_waddr;
    logic [31:0]    r_wdata;
    logic           r_busy;
    logic           r_done;
    logic           r_err;
    logic [AW:0]    r_word_count;

    logic           w_accept;
    logic [31:0]    w_asm_next;

    assign w_accept   = src.byte_valid && r_byte_ready;
    assign w_asm_next = insert_byte(r_asm, r_byte_idx, src.byte_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_byte_idx   <= '0;
            r_asm        <= '0;
            r_last_seen  <= 1'b0;
            r_byte_ready <= 1'b0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_RECV;
                        r_ptr        <= '0;
                        r_byte_idx   <= '0;
                        r_asm        <= '0;
                        r_last_seen  <= 1'b0;
                        r_word_count <= '0;
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_byte_ready <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_RECV: begin
                    if (w_accept) begin
                        r_last_seen <= src.byte_last;
                        r_asm       <= w_asm_next;
                        if (r_byte_idx == 2'd3 || src.byte_last) begin
                            // Word is presented in the cycle after its final byte
                            r_state      <= S_WRITE;
                            r_byte_ready <= 1'b0;
                            r_we         <= 1'b1;
                            r_waddr      <= r_ptr;
                            r_wdata      <= w_asm_next;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    r_byte_idx <= '0;
                    r_asm      <= '0;
                    if (r_word_count != c_CNT_MAX)
                        r_word_count <= r_word_count + (AW+1)'(1);
                    if (r_last_seen) begin
                        if (r_ptr != c_LAST_ADDR) begin
                            r_state <= S_PAD;
                            r_ptr   <= r_ptr + AW'(1);
                            r_we    <= 1'b1;
                            r_waddr <= r_ptr + AW'(1);
                            r_wdata <= HALT_INSN;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_ptr == c_LAST_ADDR) begin
                        r_state      <= S_DRAIN;
                        r_err        <= 1'b1;
                        r_byte_ready <= 1'b1;
                    end else begin
                        r_state      <= S_RECV;
                        r_ptr        <= r_ptr + AW'(1);
                        r_byte_ready <= 1'b1;
                    end
                end
                S_PAD: begin
                    if (r_ptr == c_LAST_ADDR) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ptr   <= r_ptr + AW'(1);
                        r_we    <= 1'b1;
                        r_waddr <= r_ptr + AW'(1);
                        r_wdata <= HALT_INSN;
                    end
                end
                S_DRAIN: begin
                    if (w_accept && src.byte_last) begin
                        r_state      <= S_DONE;
                        r_byte_ready <= 1'b0;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_byte_ready <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign src.byte_ready = r_byte_ready;
    assign we             = r_we;
    assign waddr          = r_waddr;
    assign wdata          = r_wdata;
    assign cpu_hold       = r_busy;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err_overflow   = r_err;
    assign word_count     = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Scoreboard bench for imem_loader; monitor checks IMEM writes.
// Revision    : 1.0
// ============================================================================
module tb_imem_loader;
    localparam logic [31:0] c_HALT = 32'h0000_0063;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       we;
    logic [6:0] waddr;
    logic [31:0] wdata;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       err_overflow;
    logic [7:0] word_count;

    imem_loader_if bif ();

    imem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .src          (bif.slave),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .err_overflow (err_overflow),
        .word_count   (word_count)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_we_cyc = 0;
    int          done_cyc = 0;
    logic [38:0] exp_q[$];
    logic [7:0]  tx_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every IMEM write is popped against the expected queue
    initial forever begin
        @(negedge clk);
        if (rst_n && we) begin
            last_we_cyc = cyc;
            chk("ready_low_on_write", 64'(bif.byte_ready), 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {25'd0, waddr, wdata}, 64'h7FFF_FFFF_FFFF);
            end else begin
                logic [38:0] e;
                e = exp_q.pop_front();
                chk("write_addr_data", {25'd0, waddr, wdata}, {25'd0, e});
            end
        end
    end

    task automatic push_w(input int a, input logic [31:0] d);
        exp_q.push_back({7'(a), d});
    endtask

    task automatic push_pad(input int from);
        for (int a = from; a < 128; a++) push_w(a, c_HALT);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends tx_q with byte_last on the final byte; starts and ends at a negedge.
    task automatic send_stream(input bit stall);
        for (int i = 0; i < tx_q.size(); i++) begin
            int t;
            if (stall) begin
                int gap;
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    start = (g == 0 && i > 0);
                    @(negedge clk);
                    start = 1'b0;
                end
            end
            bif.byte_valid = 1'b1;
            bif.byte_data  = tx_q[i];
            bif.byte_last  = (i == tx_q.size() - 1);
            t = 0;
            while (!bif.byte_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) begin
                chk("handshake_timeout", 64'(t), 64'd0);
                bif.byte_valid = 1'b0;
                return;
            end
            @(negedge clk);
            bif.byte_valid = 1'b0;
            bif.byte_last  = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        done_cyc = cyc;
        chk("done_timeout", 64'(done), 64'd1);
        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        chk("busy_after_load", 64'(busy), 64'd0);
        chk("cpu_hold_after_load", 64'(cpu_hold), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_byte_ready"}, 64'(bif.byte_ready), 64'd0);
        chk({tag, "_we"}, 64'(we), 64'd0);
        chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err_overflow), 64'd0);
        chk({tag, "_waddr"}, 64'(waddr), 64'd0);
        chk({tag, "_wdata"}, 64'(wdata), 64'd0);
        chk({tag, "_word_count"}, 64'(word_count), 64'd0);
    endtask

    task automatic load_prog1(input bit stall);
        tx_q = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        push_w(0, 32'h00A0_0513);
        push_w(1, 32'h0010_0593);
        push_pad(2);
        pulse_start();
        send_stream(stall);
        wait_done();
        chk("p1_word_count", 64'(word_count), 64'd2);
        chk("p1_done", 64'(done), 64'd1);
        chk("p1_err", 64'(err_overflow), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'h00;
        bif.byte_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        load_prog1(1'b0);

        // Partial final word
        tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        push_w(0, 32'hDDCC_BBAA);
        push_w(1, 32'h0000_00EE);
        push_pad(2);
        pulse_start();
        send_stream(1'b0);
        wait_done();
        chk("p2_word_count", 64'(word_count), 64'd2);
        chk("p2_err", 64'(err_overflow), 64'd0);

        // Exactly full: 512 bytes, no pad
        tx_q.delete();
        for (int i = 0; i < 512; i++) tx_q.push_back(8'(i));
        push_w(0, 32'h0302_0100);
        push_w(1, 32'h0706_0504);
        for (int k = 2; k < 128; k++)
            push_w(k, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        pulse_start();
        send_stream(1'b0);
        wait_done();
        chk("full_done_latency", 64'(done_cyc), 64'(last_we_cyc + 1));
        chk("full_word_count", 64'(word_count), 64'd128);
        chk("full_err", 64'(err_overflow), 64'd0);

        // Overflow: 520 bytes, tail drained
        tx_q.delete();
        for (int i = 0; i < 520; i++) tx_q.push_back(8'(i));
        for (int k = 0; k < 128; k++)
            push_w(k, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        pulse_start();
        send_stream(1'b0);
        wait_done();
        chk("ovf_word_count", 64'(word_count), 64'd128);
        chk("ovf_err", 64'(err_overflow), 64'd1);
        chk("ovf_done", 64'(done), 64'd1);

        // Stalled source with start pulses while busy
        load_prog1(1'b1);

        // Asynchronous reset during PAD, then reload
        tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        push_w(0, 32'hDDCC_BBAA);
        push_w(1, 32'h0000_00EE);
        push_pad(2);
        pulse_start();
        send_stream(1'b0);
        begin
            int t;
            t = 0;
            while (!(we && waddr == 7'd20) && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("pad_reached", 64'(waddr), 64'd20);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_prog1(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
